// File: rtl/commit_arbiter.sv
// Commit stage: per-channel result FIFOs, rotating-priority single-write arbiter
// into the ROB with empty-FIFO bypass, and register-address forwarding to issue.
module commit_arbiter #(
  parameter int CHANNELS   = 3,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int FWD_PORTS  = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 flush_i,
  input  logic                                 stall_i,
  output logic                                 stall_o,
  input  logic [CHANNELS-1:0]                  valid_i,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  result_i,
  input  logic [CHANNELS-1:0][TAG_WIDTH-1:0]   tag_i,
  input  logic [CHANNELS-1:0][4:0]             reg_dest_i,
  input  logic [CHANNELS-1:0]                  exc_i,
  output logic                                 rob_write_o,
  output logic [TAG_WIDTH-1:0]                 rob_tag_o,
  output logic [DATA_WIDTH-1:0]                rob_result_o,
  output logic [4:0]                           rob_reg_dest_o,
  output logic                                 rob_exc_o,
  input  logic [FWD_PORTS-1:0][4:0]            fwd_src_i,
  output logic [FWD_PORTS-1:0][DATA_WIDTH-1:0] fwd_data_o,
  output logic [FWD_PORTS-1:0]                 fwd_valid_o,
  output logic                                 overflow_o
);

  localparam int PW = $clog2(CHANNELS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] data_q [CHANNELS][DEPTH];
  logic [DATA_WIDTH-1:0] data_d [CHANNELS][DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [CHANNELS][DEPTH];
  logic [TAG_WIDTH-1:0]  tag_d  [CHANNELS][DEPTH];
  logic [4:0]            dst_q  [CHANNELS][DEPTH];
  logic [4:0]            dst_d  [CHANNELS][DEPTH];
  logic                  exc_q  [CHANNELS][DEPTH];
  logic                  exc_d  [CHANNELS][DEPTH];
  logic                  fok_q  [CHANNELS][DEPTH];
  logic                  fok_d  [CHANNELS][DEPTH];
  logic [AW-1:0]         rd_q   [CHANNELS];
  logic [AW-1:0]         rd_d   [CHANNELS];
  logic [AW-1:0]         wr_q   [CHANNELS];
  logic [AW-1:0]         wr_d   [CHANNELS];
  logic [CW-1:0]         cnt_q  [CHANNELS];
  logic [CW-1:0]         cnt_d  [CHANNELS];
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  ovf_q, ovf_d;

  logic [CHANNELS-1:0] req, pop, byp, push, push_ok, first_w;
  logic                grant_any, wr_en, head_sel;
  logic [PW-1:0]       gnt;

  always_comb begin
    grant_any = 1'b0;
    gnt       = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      req[j]     = (cnt_q[j] != '0) | valid_i[j];
      // only the lowest-index same-cycle writer of a register stays forwardable
      first_w[j] = 1'b1;
      for (int i = 0; i < j; i++)
        if (valid_i[i] && reg_dest_i[i] == reg_dest_i[j]) first_w[j] = 1'b0;
    end
    for (int o = 0; o < CHANNELS; o++) begin
      if (!grant_any && req[(int'(ptr_q) + o) % CHANNELS]) begin
        grant_any = 1'b1;
        gnt       = PW'((int'(ptr_q) + o) % CHANNELS);
      end
    end
    wr_en    = grant_any & ~stall_i & ~flush_i & rst_n_i;
    head_sel = cnt_q[gnt] != '0;
    for (int j = 0; j < CHANNELS; j++) begin
      pop[j]  = wr_en & (gnt == PW'(j)) & (cnt_q[j] != '0);
      byp[j]  = wr_en & (gnt == PW'(j)) & (cnt_q[j] == '0);
      push[j] = valid_i[j] & ~byp[j] & ~flush_i;
    end
  end

  always_comb begin
    rob_write_o    = wr_en;
    rob_tag_o      = '0;
    rob_result_o   = '0;
    rob_reg_dest_o = '0;
    rob_exc_o      = 1'b0;
    if (wr_en) begin
      if (head_sel) begin
        rob_tag_o      = tag_q[gnt][rd_q[gnt]];
        rob_result_o   = data_q[gnt][rd_q[gnt]];
        rob_reg_dest_o = dst_q[gnt][rd_q[gnt]];
        rob_exc_o      = exc_q[gnt][rd_q[gnt]];
      end else begin
        rob_tag_o      = tag_i[gnt];
        rob_result_o   = result_i[gnt];
        rob_reg_dest_o = reg_dest_i[gnt];
        rob_exc_o      = exc_i[gnt];
      end
    end
    stall_o = 1'b0;
    for (int j = 0; j < CHANNELS; j++)
      if (cnt_q[j] >= CW'(DEPTH - 1)) stall_o = 1'b1;
    overflow_o = ovf_q;
  end

  always_comb begin
    for (int k = 0; k < FWD_PORTS; k++) begin
      fwd_valid_o[k] = 1'b0;
      fwd_data_o[k]  = '0;
      if (fwd_src_i[k] != 5'd0 && rst_n_i) begin
        for (int j = 0; j < CHANNELS; j++) begin
          if (!fwd_valid_o[k] && valid_i[j] && reg_dest_i[j] == fwd_src_i[k]) begin
            fwd_valid_o[k] = 1'b1;
            fwd_data_o[k]  = result_i[j];
          end
        end
        for (int c = 0; c < CHANNELS; c++) begin
          for (int o = 0; o < DEPTH; o++) begin
            if (!fwd_valid_o[k] && CW'(o) < cnt_q[c]
                && fok_q[c][rd_q[c] + AW'(o)]
                && dst_q[c][rd_q[c] + AW'(o)] == fwd_src_i[k]) begin
              fwd_valid_o[k] = 1'b1;
              fwd_data_o[k]  = data_q[c][rd_q[c] + AW'(o)];
            end
          end
        end
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    dst_d   = dst_q;
    exc_d   = exc_q;
    fok_d   = fok_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    push_ok = '0;
    if (flush_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_d[c]  = '0;
        wr_d[c]  = '0;
        cnt_d[c] = '0;
        for (int e = 0; e < DEPTH; e++) fok_d[c][e] = 1'b0;
      end
      ptr_d = '0;
      ovf_d = 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        for (int e = 0; e < DEPTH; e++)
          for (int j = 0; j < CHANNELS; j++)
            if (valid_i[j] && dst_q[c][e] == reg_dest_i[j]) fok_d[c][e] = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (pop[c]) rd_d[c] = rd_q[c] + 1'b1;
        if (push[c]) begin
          // a same-cycle pop frees the slot, so a full FIFO can still accept
          if (cnt_q[c] == CW'(DEPTH) && !pop[c]) begin
            ovf_d = 1'b1;
          end else begin
            push_ok[c]           = 1'b1;
            data_d[c][wr_q[c]]   = result_i[c];
            tag_d[c][wr_q[c]]    = tag_i[c];
            dst_d[c][wr_q[c]]    = reg_dest_i[c];
            exc_d[c][wr_q[c]]    = exc_i[c];
            fok_d[c][wr_q[c]]    = first_w[c];
            wr_d[c]              = wr_q[c] + 1'b1;
          end
        end
        cnt_d[c] = cnt_q[c] + CW'(push_ok[c]) - CW'(pop[c]);
      end
      if (wr_en) ptr_d = (gnt == PW'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_q[c]  <= '0;
        wr_q[c]  <= '0;
        cnt_q[c] <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          fok_q[c][e] <= 1'b0;
          dst_q[c][e] <= '0;
        end
      end
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      fok_q <= fok_d;
      dst_q <= dst_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  // payload storage is qualified by count, so it needs no reset
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    tag_q  <= tag_d;
    exc_q  <= exc_d;
  end

endmodule

// File: tb/tb_commit_arbiter.sv
// Bench for commit_arbiter: directed scenarios then random traffic, all outputs
// compared every cycle against a queue-based model of the commit rules.
module tb_commit_arbiter;
  localparam int CH = 3;
  localparam int DEPTH = 4;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int FP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, stall = 1'b0;
  logic stall_o;
  logic [CH-1:0]          valid = '0;
  logic [CH-1:0][DW-1:0]  result = '0;
  logic [CH-1:0][TW-1:0]  tag = '0;
  logic [CH-1:0][4:0]     rdst = '0;
  logic [CH-1:0]          exc = '0;
  logic                   rob_write_o;
  logic [TW-1:0]          rob_tag_o;
  logic [DW-1:0]          rob_result_o;
  logic [4:0]             rob_reg_dest_o;
  logic                   rob_exc_o;
  logic [FP-1:0][4:0]     fsrc = '0;
  logic [FP-1:0][DW-1:0]  fwd_data_o;
  logic [FP-1:0]          fwd_valid_o;
  logic                   overflow_o;

  commit_arbiter #(.CHANNELS(CH), .DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                   .FWD_PORTS(FP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall), .stall_o(stall_o),
    .valid_i(valid), .result_i(result), .tag_i(tag), .reg_dest_i(rdst), .exc_i(exc),
    .rob_write_o(rob_write_o), .rob_tag_o(rob_tag_o), .rob_result_o(rob_result_o),
    .rob_reg_dest_o(rob_reg_dest_o), .rob_exc_o(rob_exc_o), .fwd_src_i(fsrc),
    .fwd_data_o(fwd_data_o), .fwd_valid_o(fwd_valid_o), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic [4:0]    r;
    logic          e;
    bit            fok;
  } ent_t;

  ent_t mq [CH][$];
  int   mptr = 0;
  bit   movf = 1'b0;
  int   n_pass = 0, n_total = 0, n_fail = 0;

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    mptr = 0;
    movf = 1'b0;
  endtask

  task automatic model_and_check();
    bit any, wr, hit, sfull;
    int g;
    ent_t h, x;
    logic [DW-1:0] fd;
    any = 1'b0; g = 0;
    for (int o = 0; o < CH; o++) begin
      int c;
      c = (mptr + o) % CH;
      if (!any && (mq[c].size() > 0 || valid[c])) begin any = 1'b1; g = c; end
    end
    wr = any && !stall && !flush;
    h = '{d: '0, t: '0, r: '0, e: 1'b0, fok: 1'b0};
    if (wr) begin
      if (mq[g].size() > 0) h = mq[g][0];
      else h = '{d: result[g], t: tag[g], r: rdst[g], e: exc[g], fok: 1'b0};
    end
    chk("rob_write", rob_write_o, wr);
    chk("rob_tag", rob_tag_o, h.t);
    chk("rob_result", rob_result_o, h.d);
    chk("rob_reg_dest", rob_reg_dest_o, h.r);
    chk("rob_exc", rob_exc_o, h.e);
    sfull = 1'b0;
    for (int c = 0; c < CH; c++) if (mq[c].size() >= DEPTH - 1) sfull = 1'b1;
    chk("stall_o", stall_o, sfull);
    chk("overflow_o", overflow_o, movf);
    for (int k = 0; k < FP; k++) begin
      hit = 1'b0; fd = '0;
      if (fsrc[k] != 0) begin
        for (int j = 0; j < CH; j++)
          if (!hit && valid[j] && rdst[j] == fsrc[k]) begin hit = 1'b1; fd = result[j]; end
        for (int c = 0; c < CH; c++)
          foreach (mq[c][i])
            if (!hit && mq[c][i].fok && mq[c][i].r == fsrc[k]) begin hit = 1'b1; fd = mq[c][i].d; end
      end
      chk($sformatf("fwd_valid[%0d]", k), fwd_valid_o[k], hit);
      chk($sformatf("fwd_data[%0d]", k), fwd_data_o[k], fd);
    end
    if (flush) begin
      model_reset();
    end else begin
      bit bypassed;
      for (int c = 0; c < CH; c++)
        foreach (mq[c][i])
          for (int j = 0; j < CH; j++)
            if (valid[j] && mq[c][i].r == rdst[j]) begin
              x = mq[c][i]; x.fok = 1'b0; mq[c][i] = x;
            end
      bypassed = 1'b0;
      if (wr) begin
        if (mq[g].size() > 0) void'(mq[g].pop_front());
        else bypassed = 1'b1;
        mptr = (g + 1) % CH;
      end
      for (int j = 0; j < CH; j++) begin
        if (valid[j] && !(bypassed && g == j)) begin
          if (mq[j].size() == DEPTH) movf = 1'b1;
          else begin
            x = '{d: result[j], t: tag[j], r: rdst[j], e: exc[j], fok: 1'b1};
            for (int i = 0; i < j; i++) if (valid[i] && rdst[i] == rdst[j]) x.fok = 1'b0;
            mq[j].push_back(x);
          end
        end
      end
    end
  endtask

  task automatic cycle();
    #2;
    model_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [DW-1:0] d, input logic [TW-1:0] t,
                       input logic [4:0] r, input logic e);
    valid[ch] = 1'b1; result[ch] = d; tag[ch] = t; rdst[ch] = r; exc[ch] = e;
  endtask

  initial begin
    #1;
    chk("reset rob_write", rob_write_o, 0);
    chk("reset stall_o", stall_o, 0);
    chk("reset overflow", overflow_o, 0);
    chk("reset fwd_valid", fwd_valid_o, 0);
    chk("reset rob_result", rob_result_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // single bypassed result
    drive(1, 32'h1234, 6'd5, 5'd7, 1'b0); fsrc[0] = 5'd7;
    cycle();
    valid = '0; cycle();
    // ptr back to 0 via a ch2 write, then three-way contention
    drive(2, 32'h22, 6'd9, 5'd3, 1'b0); cycle();
    valid = '0; cycle();
    drive(0, 32'hA0, 6'd1, 5'd1, 1'b0);
    drive(1, 32'hA1, 6'd2, 5'd2, 1'b1);
    drive(2, 32'hA2, 6'd3, 5'd4, 1'b0);
    fsrc[0] = 5'd2; fsrc[1] = 5'd4;
    cycle();
    valid = '0;
    for (int i = 0; i < 3; i++) cycle();

    // stall with ch2 pushes past full
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(2, 32'h100 + i, 6'(10 + i), 5'(10 + i), 1'b0);
      fsrc[0] = 5'(10 + i);
      cycle();
    end
    valid = '0;
    #2;
    chk("overflow after fifth push", overflow_o, 1);
    chk("stall_o at full", stall_o, 1);
    #0;
    stall = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // forwarding priority: newer input shadows older buffered x9
    stall = 1'b1;
    drive(0, 32'hAA, 6'd20, 5'd9, 1'b0); fsrc[0] = 5'd9; fsrc[1] = 5'd0;
    cycle();
    valid = '0;
    drive(2, 32'hBB, 6'd21, 5'd9, 1'b0);
    cycle();
    valid = '0;
    #1;
    chk("fwd newest x9", fwd_data_o[0], 32'hBB);
    chk("fwd src0 invalid", fwd_valid_o[1], 0);
    cycle();

    // flush with buffered entries and a live ch2 input
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h300 + i, 6'(30 + i), 5'(20 + i), 1'b0);
      drive(1, 32'h400 + i, 6'(40 + i), 5'(22 + i), 1'b0);
      cycle();
    end
    valid = '0;
    flush = 1'b1;
    drive(2, 32'h555, 6'd50, 5'd25, 1'b0);
    cycle();
    flush = 1'b0; valid = '0; stall = 1'b0;
    cycle();
    cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < CH; j++) begin
        valid[j]  = ($urandom_range(0, 99) < 45);
        result[j] = $urandom;
        tag[j]    = TW'($urandom);
        rdst[j]   = 5'($urandom_range(0, 7));
        exc[j]    = ($urandom_range(0, 9) == 0);
      end
      for (int k = 0; k < FP; k++) fsrc[k] = 5'($urandom_range(0, 7));
      stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 3);
      cycle();
    end
    flush = 1'b0; stall = 1'b0;

    // asynchronous reset mid-burst
    stall = 1'b1;
    for (int j = 0; j < CH; j++) drive(j, 32'h700 + j, 6'(j), 5'(j + 1), 1'b0);
    cycle();
    stall = 1'b0; fsrc[0] = 5'd1;
    #1 rst_n = 1'b0;
    #1;
    chk("async rst rob_write", rob_write_o, 0);
    chk("async rst rob_result", rob_result_o, 0);
    chk("async rst stall_o", stall_o, 0);
    chk("async rst overflow", overflow_o, 0);
    chk("async rst fwd_valid", fwd_valid_o, 0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    valid = '0;
    drive(0, 32'hBEEF, 6'd7, 5'd6, 1'b0);
    cycle();
    valid = '0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/commit_arbiter.md
# commit_arbiter

N-channel, parametrised commit stage between the execution units and the reorder buffer. Each execution channel owns a result FIFO; a rotating-priority arbiter writes at most one result per cycle into the ROB, bypassing the FIFO when a granted channel is empty. Buffered and in-flight results are forwarded to issue by register address, newest value first. It generalises the fixed two-buffer ITU/LSU commit scheme to any channel count and depth, and adds an early-stall margin and overflow detection.

## Interface
- CHANNELS, 3, execution channels (>=2)
- DEPTH, 4, FIFO entries per channel (power of 2, >=2)
- DATA_WIDTH, 32, result width
- TAG_WIDTH, 6, ROB tag width
- FWD_PORTS, 2, forwarding source ports
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous pipeline flush
- stall_i  in  1  ROB cannot accept this cycle
- stall_o  out  1  upstream must stop issuing
- valid_i  in  CHANNELS  result valid per channel
- result_i  in  CHANNELS x DATA_WIDTH  result data
- tag_i  in  CHANNELS x TAG_WIDTH  ROB tag
- reg_dest_i  in  CHANNELS x 5  destination register
- exc_i  in  CHANNELS  exception flag
- rob_write_o  out  1  ROB write strobe
- rob_tag_o / rob_result_o / rob_reg_dest_o / rob_exc_o  out  TAG_WIDTH / DATA_WIDTH / 5 / 1  ROB entry
- fwd_src_i  in  FWD_PORTS x 5  register to forward
- fwd_data_o  out  FWD_PORTS x DATA_WIDTH  forwarded value
- fwd_valid_o  out  FWD_PORTS  forwarded value valid
- overflow_o  out  1  sticky error: push into full FIFO

## Operation
- Request: channel j requests when FIFO j is non-empty or valid_i[j]=1.
- Grant: first requesting channel found scanning j = ptr, ptr+1, ... mod CHANNELS. ptr is a log2(CHANNELS)-bit register.
- Granted channel source: FIFO head if non-empty, else the live input (bypass, not pushed).
- Pushes: every valid_i[j] is pushed, unless it was bypassed this cycle. If the granted channel has a non-empty FIFO and valid_i=1, the head is popped and the input pushed in the same cycle; count is unchanged.
- Write: rob_write_o = grant_any & !stall_i & !flush_i. On a write, ptr <= (granted+1) mod CHANNELS. With no write, ptr holds.
- stall_i=1: no pop, no bypass, ptr holds, all valid inputs pushed. ROB output fields are driven to 0 whenever rob_write_o=0.
- stall_o = OR over channels of (count_j >= DEPTH-1). This leaves one slot of slack for the cycle of upstream reaction.
- Overflow: a push into a channel with count=DEPTH is dropped and sets overflow_o. overflow_o is cleared only by reset or flush.
- flush_i: empties all FIFOs, ptr <= 0, overflow_o <= 0. Inputs in that cycle are discarded. Outputs stay combinational: rob_write_o=0, but fwd_* still reflect the pre-flush state.
- Forward bit: each buffered entry has a fwd_ok bit, set on push. Any valid input (pushed or bypassed) with reg_dest r clears fwd_ok of every buffered entry in every channel whose reg_dest is r. At most one forwardable buffered copy per register exists.
- Forward port k, src s:
  - s=0: fwd_valid_o[k]=0 and data=0.
  - Otherwise the lowest-index valid input with reg_dest=s wins.
  - Else the unique buffered entry with fwd_ok and reg_dest=s.
  - Else fwd_valid_o[k]=0 and data=0.
  - Entries leave the forward set when popped.

## Timing
- Reset values: stall_o=0, rob_write_o=0, all rob_* = 0, fwd_valid_o=0, fwd_data_o=0, overflow_o=0, ptr=0, counts=0.
- Bypass latency: 0 cycles, with the input to rob_* in the same cycle. Buffered latency: at least 1 cycle.
- stall_o, rob_* and fwd_* are combinational from current state and inputs. FIFO, ptr and overflow update on the clock edge.
- Per-channel order is strictly FIFO. No ordering is guaranteed across channels; the ROB reorders by tag.
- Worst-case wait for a non-empty channel: CHANNELS-1 writes.
- Asynchronous reset mid-operation clears all state immediately; no partial write is emitted.

## Test plan
- Single result: ch1 valid, tag 5, x7=0x1234, all FIFOs empty, stall_i=0 -> same cycle rob_write_o=1, tag 5, result 0x1234; FIFO1 count stays 0.
- Contention: ch0/ch1/ch2 valid on one cycle, ptr=0 -> ch0 bypassed in cycle 0; ch1 written cycle 1, ch2 cycle 2; ptr ends at 0.
- Stall/backpressure: stall_i=1 with ch2 valid for 3 cycles -> count 3, stall_o=1 after cycle 2 (count=3=DEPTH-1), no writes. Fourth push fills the FIFO; a fifth sets overflow_o=1. Release stall -> entries written in push order.
- Forward priority: x9 buffered 0xAA in ch0, then ch2 input x9=0xBB -> fwd_src=9 gives 0xBB that cycle and the following ones (old entry's fwd_ok cleared); fwd_src=0 -> fwd_valid_o=0.
- Flush: 2 entries each in ch0 and ch1, flush_i=1 with ch2 valid -> next cycle all counts 0, ptr 0, overflow_o 0, no rob write for the ch2 input.
- Reset: assert rst_n_i low mid-burst between clock edges -> all outputs 0 immediately; after release, first valid input is bypassed normally.
